// File: rtl/usb11_pkg.sv
// rtl/usb11_pkg.sv - shared constants and FSM encoding for the low-speed USB 1.1 transmitter
package usb11_pkg;

    localparam int CLKS_PER_BIT_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    // Line states packed as {dp, dm}
    localparam logic [1:0] LINE_J   = 2'b01;
    localparam logic [1:0] LINE_K   = 2'b10;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0]  SYNC_PATTERN = 8'h80;
    localparam logic [2:0]  STUFF_LIMIT  = 3'd6;
    localparam logic [15:0] CRC16_POLY   = 16'h8005;
    localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usb11_crc16.sv
// rtl/usb11_crc16.sv - serial CRC16 (poly 0x8005), one message bit per enable
module usb11_crc16
    import usb11_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = CRC16_INIT;
        end else if (en_i) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (((bit_i ^ crc_q[15]) == 1'b1) ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/usb11_send.sv
// rtl/usb11_send.sv - low-speed USB 1.1 packet transmitter: SYNC, bit stuffing, NRZI, EOP
// Optional CRC16 trailer when USB11_SEND_CRC16_EN is defined.
module usb11_send
    import usb11_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    input  logic       tx_crc16,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun,
    output logic       dp,
    output logic       dm,
    output logic       oe
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0]  cnt_q, cnt_d;      // bits of the current field already put on the wire
    logic [7:0]  shift_q, shift_d;
    logic        last_q, last_d;
    logic [2:0]  ones_q, ones_d;
    logic [1:0]  line_q, line_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic tick, need_byte, emit_bit, bit_out, go_eop, load_byte, data_bit;

    assign tick      = (timer_q == TIMER_LAST);
    assign need_byte = (cnt_q == 5'd8) &&
                       ((state_q == ST_SYNC) || ((state_q == ST_DATA) && !last_q));

`ifdef USB11_SEND_CRC16_EN
    logic        crc_on_q, pid_q, crc_en, crc_init;
    logic [15:0] crc_val;

    assign crc_init = (state_q == ST_IDLE) && tx_start;
    // The first byte of a packet is the PID and stays out of the CRC.
    assign crc_en   = data_bit && !(load_byte ? (state_q == ST_SYNC) : pid_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_on_q <= 1'b0;
            pid_q    <= 1'b0;
        end else begin
            if (crc_init) crc_on_q <= tx_crc16;
            if (load_byte) pid_q <= (state_q == ST_SYNC);
        end
    end

    usb11_crc16 u_crc16 (
        .clk    (clk),
        .rst_n  (rst_n),
        .init_i (crc_init),
        .en_i   (crc_en),
        .bit_i  (bit_out),
        .crc_o  (crc_val)
    );
`else
    logic unused_crc;
    assign unused_crc = ^{tx_crc16, data_bit};
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        last_d      = last_q;
        ones_d      = ones_q;
        line_d      = line_q;
        oe_d        = oe_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        emit_bit    = 1'b0;
        bit_out     = 1'b0;
        go_eop      = 1'b0;
        load_byte   = 1'b0;
        data_bit    = 1'b0;
        tx_ready    = 1'b0;
        tx_underrun = 1'b0;

        if (busy_q) timer_d = tick ? '0 : timer_q + 1'b1;

        if (state_q == ST_IDLE) begin
            if (tx_start) begin
                state_d  = ST_SYNC;
                oe_d     = 1'b1;
                busy_d   = 1'b1;
                timer_d  = '0;
                cnt_d    = 5'd1;
                emit_bit = 1'b1;
                bit_out  = SYNC_PATTERN[0];
            end
        end else if (tick) begin
            if (ones_q == STUFF_LIMIT) begin
                // Stuffed zero: consumes nothing, so the field counters stay put.
                emit_bit = 1'b1;
                bit_out  = 1'b0;
            end else if (need_byte) begin
                if (tx_valid) begin
                    tx_ready  = 1'b1;
                    load_byte = 1'b1;
                    data_bit  = 1'b1;
                    state_d   = ST_DATA;
                    shift_d   = {1'b0, tx_data[7:1]};
                    last_d    = tx_last;
                    cnt_d     = 5'd1;
                    emit_bit  = 1'b1;
                    bit_out   = tx_data[0];
                end else begin
                    tx_underrun = 1'b1;
                    go_eop      = 1'b1;
                end
            end else begin
                case (state_q)
                    ST_SYNC: begin
                        emit_bit = 1'b1;
                        bit_out  = SYNC_PATTERN[cnt_q[2:0]];
                        cnt_d    = cnt_q + 5'd1;
                    end
                    ST_DATA: begin
                        if (cnt_q != 5'd8) begin
                            emit_bit = 1'b1;
                            data_bit = 1'b1;
                            bit_out  = shift_q[0];
                            shift_d  = {1'b0, shift_q[7:1]};
                            cnt_d    = cnt_q + 5'd1;
                        end
`ifdef USB11_SEND_CRC16_EN
                        else if (crc_on_q) begin
                            state_d  = ST_CRC;
                            cnt_d    = 5'd1;
                            emit_bit = 1'b1;
                            bit_out  = ~crc_val[15];
                        end
`endif
                        else begin
                            go_eop = 1'b1;
                        end
                    end
`ifdef USB11_SEND_CRC16_EN
                    ST_CRC: begin
                        if (cnt_q != 5'd16) begin
                            emit_bit = 1'b1;
                            bit_out  = ~crc_val[4'd15 - cnt_q[3:0]];
                            cnt_d    = cnt_q + 5'd1;
                        end else begin
                            go_eop = 1'b1;
                        end
                    end
`endif
                    ST_EOP_SE0: begin
                        if (cnt_q == 5'd1) begin
                            cnt_d = 5'd2;
                        end else begin
                            state_d = ST_EOP_J;
                            line_d  = LINE_J;
                        end
                    end
                    ST_EOP_J: begin
                        state_d = ST_IDLE;
                        oe_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        timer_d = '0;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        if (go_eop) begin
            state_d = ST_EOP_SE0;
            cnt_d   = 5'd1;
            line_d  = LINE_SE0;
            ones_d  = '0;
        end

        if (emit_bit) begin
            line_d = bit_out ? line_q : nrzi_toggle(line_q);
            ones_d = bit_out ? ones_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            last_q  <= 1'b0;
            ones_q  <= '0;
            line_q  <= LINE_J;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            ones_q  <= ones_d;
            line_q  <= line_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign dp      = line_q[1];
    assign dm      = line_q[0];
    assign oe      = oe_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_usb11_send.sv
// tb/tb_usb11_send.sv - scoreboard bench for usb11_send against a bit-list reference model
module tb_usb11_send;

    localparam int CPB = 8;
    localparam logic [1:0] J = 2'b01;
    localparam logic [1:0] K = 2'b10;
    localparam logic [1:0] SE0 = 2'b00;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_start = 1'b0, tx_valid = 1'b0, tx_last = 1'b0, tx_crc16 = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic tx_ready, tx_busy, tx_done, tx_underrun, dp, dm, oe;

    int errors = 0;
    int checks = 0;

    logic [1:0] exp_sym_q[$];
    int exp_len_q[$];
    int exp_rdy_q[$];
    int exp_urun_q[$];
    logic [7:0] pkt[$];
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    usb11_send #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_crc16    (tx_crc16),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_underrun (tx_underrun),
        .dp          (dp),
        .dm          (dm),
        .oe          (oe)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: raw bit list -> stuffing pass -> NRZI -> EOP symbols.
    task automatic push_expected(input logic [7:0] bytes[$], input bit urun, input bit crc);
        bit raw[$];
        bit stuffed[$];
        int ones;
        logic [1:0] line;
        logic [15:0] crcv;
        logic fb;
        for (int i = 0; i < 8; i++) raw.push_back(i == 7);
        foreach (bytes[b]) for (int i = 0; i < 8; i++) raw.push_back(bytes[b][i]);
        if (crc && !urun) begin
            crcv = 16'hFFFF;
            for (int b = 1; b < bytes.size(); b++) begin
                for (int i = 0; i < 8; i++) begin
                    fb = crcv[0] ^ bytes[b][i];
                    crcv = (crcv >> 1) ^ (fb ? 16'hA001 : 16'h0000);
                end
            end
            for (int i = 0; i < 16; i++) raw.push_back(crcv[i] == 1'b0);
        end
        ones = 0;
        foreach (raw[i]) begin
            stuffed.push_back(raw[i]);
            if (raw[i]) begin
                ones++;
                if (ones == 6) begin
                    stuffed.push_back(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        line = J;
        foreach (stuffed[i]) begin
            if (!stuffed[i]) line = (line == J) ? K : J;
            exp_sym_q.push_back(line);
        end
        exp_sym_q.push_back(SE0);
        exp_sym_q.push_back(SE0);
        exp_sym_q.push_back(J);
        exp_len_q.push_back(stuffed.size() + 3);
        exp_rdy_q.push_back(bytes.size());
        exp_urun_q.push_back(int'(urun));
    endtask

    // Monitor: samples each bit time mid-bit and closes the packet when oe drops.
    int m_cyc = 0, m_rdy = 0, m_urun = 0;
    bit m_active = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                m_active = 1'b0;
            end else begin
                if (tx_ready) m_rdy++;
                if (tx_underrun) m_urun++;
                if (oe) begin
                    if (!m_active) begin
                        m_active = 1'b1;
                        m_cyc = 0;
                    end
                    if (m_cyc % CPB == CPB / 2) begin
                        check("sym_avail", int'(exp_sym_q.size() > 0), 1);
                        if (exp_sym_q.size() > 0) check("line_bit", {dp, dm}, exp_sym_q.pop_front());
                        check("busy_in_pkt", tx_busy, 1);
                    end
                    m_cyc++;
                end else if (m_active) begin
                    m_active = 1'b0;
                    check("done_pulse", tx_done, 1);
                    check("idle_line", {dp, dm}, J);
                    check("len_avail", int'(exp_len_q.size() > 0), 1);
                    if (exp_len_q.size() > 0) begin
                        check("oe_clks", m_cyc, exp_len_q.pop_front() * CPB);
                        check("ready_count", m_rdy, exp_rdy_q.pop_front());
                        check("underrun_count", m_urun, exp_urun_q.pop_front());
                    end
                    m_rdy = 0;
                    m_urun = 0;
                end
            end
        end
    end

    // urun_at: index of the byte withheld to force an underrun, -1 for none
    task automatic send(input logic [7:0] bytes[$], input int urun_at, input bit crc, input bit glitch);
        logic [7:0] sent[$];
        int n;
        int t;
        n = (urun_at >= 0) ? urun_at : bytes.size();
        for (int i = 0; i < n; i++) sent.push_back(bytes[i]);
        push_expected(sent, urun_at >= 0, crc);
        @(posedge clk); #1;
        tx_start = 1'b1;
        tx_crc16 = crc;
        @(posedge clk); #1;
        tx_start = 1'b0;
        tx_crc16 = 1'b0;
        if (glitch) begin
            fork
                begin
                    repeat (40) @(posedge clk);
                    #1 tx_start = 1'b1;
                    tx_crc16 = ~crc;
                    @(posedge clk);
                    #1 tx_start = 1'b0;
                    tx_crc16 = 1'b0;
                end
            join_none
        end
        for (int i = 0; i < n; i++) begin
            tx_data = bytes[i];
            tx_valid = 1'b1;
            tx_last = (urun_at < 0) && (i == n - 1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!tx_ready && t < 400);
            check("ready_seen", tx_ready, 1);
            @(posedge clk); #1;
        end
        tx_valid = 1'b0;
        tx_last = 1'b0;
        tx_data = 8'($urandom);
        t = 0;
        while (!tx_done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", tx_done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, u;
        bit c;
        repeat (3) @(posedge clk);
        #1;
        check("rst_oe", oe, 0);
        check("rst_line", {dp, dm}, J);
        check("rst_busy", tx_busy, 0);
        check("rst_ready", tx_ready, 0);
        check("rst_done", tx_done, 0);
        check("rst_underrun", tx_underrun, 0);
        rst_n = 1'b1;

        // Asynchronous reset in the middle of the payload
        @(posedge clk); #1;
        tx_start = 1'b1;
        @(posedge clk); #1;
        tx_start = 1'b0;
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        tx_last = 1'b1;
        repeat (100) @(posedge clk);
        #3;
        check("mid_oe", oe, 1);
        rst_n = 1'b0;
        #1;
        check("async_oe", oe, 0);
        check("async_busy", tx_busy, 0);
        check("async_line", {dp, dm}, J);
        @(posedge clk); #1;
        rst_n = 1'b1;
        tx_valid = 1'b0;
        tx_last = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("post_rst_oe", oe, 0);
        check("post_rst_busy", tx_busy, 0);
        check("post_rst_line", {dp, dm}, J);

        mon_en = 1'b1;
        pkt = {8'hA5};
        send(pkt, -1, 1'b0, 1'b0);
        pkt = {8'hFF};
        send(pkt, -1, 1'b0, 1'b0);
        pkt = {8'h12, 8'h34};
        send(pkt, 1, 1'b0, 1'b0);
        pkt = {8'h77};
        send(pkt, 0, 1'b0, 1'b0);
        pkt = {8'h5A, 8'hFF, 8'hFF};
        send(pkt, -1, 1'b0, 1'b1);
        pkt = {8'hFC, 8'h3F};
        send(pkt, -1, 1'b0, 1'b0);
`ifdef USB11_SEND_CRC16_EN
        pkt = {8'hC3};
        send(pkt, -1, 1'b1, 1'b0);
        pkt = {8'hC3, 8'h01, 8'hFF, 8'h80};
        send(pkt, -1, 1'b1, 1'b0);
`endif
        for (int p = 0; p < 25; p++) begin
            n = $urandom_range(1, 5);
            pkt.delete();
            for (int i = 0; i < n; i++)
                pkt.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            u = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            c = 1'b0;
`ifdef USB11_SEND_CRC16_EN
            c = 1'($urandom_range(0, 1));
`endif
            send(pkt, u, c, p % 7 == 3);
        end

        repeat (20) @(posedge clk);
        check("sym_left", exp_sym_q.size(), 0);
        check("pkt_left", exp_len_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
